// File: rtl/master_port_if.sv
`default_nettype none
// ============================================================================
// master_port_if -- local request/response and serial-link signals of master_port
// Rev 1.0
// ============================================================================
interface master_port_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_mode;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_err;
  logic                  mode;
  logic                  wr_bus;
  logic                  master_valid;
  logic                  slave_ready;
  logic                  rd_bus;
  logic                  slave_valid;
  logic                  master_ready;

  modport master (
    input  req_valid, req_mode, req_addr, req_wdata, slave_ready, rd_bus, slave_valid,
    output req_ready, resp_valid, resp_rdata, resp_err, mode, wr_bus, master_valid,
           master_ready
  );

  modport slave (
    output req_valid, req_mode, req_addr, req_wdata, slave_ready, rd_bus, slave_valid,
    input  req_ready, resp_valid, resp_rdata, resp_err, mode, wr_bus, master_valid,
           master_ready
  );
endinterface
`default_nettype wire

// File: rtl/master_port.sv
`default_nettype none
// ============================================================================
// master_port -- serial system-bus initiator; optional watchdog via MASTER_PORT_TIMEOUT_EN
// Rev 1.0
// ============================================================================
module master_port #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic          clk,
  input  logic          rstn,
  master_port_if.master bus
);
  localparam int TOTAL = ADDR_WIDTH + DATA_WIDTH;
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam logic [CNT_W-1:0] LAST_TX = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] LAST_RX = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, REQ, SHIFT, WAIT_RD, RX, ACK, DONE, ABORT} state_t;

  state_t                state_q, state_d;
  logic [TOTAL-1:0]      shift_q, shift_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] rx_q, rx_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  mode_q, mode_d;
  logic                  tx_active;
  logic                  wd_expired;

  assign tx_active = (state_q == REQ) || (state_q == SHIFT);

`ifdef MASTER_PORT_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            wd_armed;

  // Counts consecutive handshake-less cycles in the waiting states only.
  always_comb begin
    wd_d       = '0;
    wd_expired = 1'b0;
    wd_armed   = ((state_q == REQ) && !bus.slave_ready) ||
                 (((state_q == WAIT_RD) || (state_q == RX)) && !bus.slave_valid);
    if (wd_armed) begin
      wd_d       = wd_q + WD_W'(1);
      wd_expired = (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) wd_q <= '0;
    else       wd_q <= wd_d;
  end
`else
  logic [31:0] timeout_unused;
  assign timeout_unused = 32'(TIMEOUT_CYCLES);
  assign wd_expired     = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    rdata_d   = rdata_q;
    mode_d    = mode_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          shift_d   = {bus.req_addr, bus.req_wdata};
          mode_d    = bus.req_mode;
          bit_cnt_d = '0;
          state_d   = REQ;
        end
      end
      // REQ shares the shift path: the first ready cycle already moves a bit.
      REQ, SHIFT: begin
        if (bus.slave_ready) begin
          shift_d   = shift_q << 1;
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          state_d   = SHIFT;
          if (bit_cnt_q == LAST_TX) begin
            if (mode_q) begin
              state_d = DONE;
            end else begin
              state_d   = WAIT_RD;
              bit_cnt_d = '0;
            end
          end
        end else if ((state_q == SHIFT) || wd_expired) begin
          state_d = ABORT;
        end
      end
      WAIT_RD, RX: begin
        if (bus.slave_valid) begin
          rx_d      = (rx_q << 1) | DATA_WIDTH'(bus.rd_bus);
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          state_d   = (bit_cnt_q == LAST_RX) ? ACK : RX;
        end else if (wd_expired) begin
          state_d = ABORT;
        end
      end
      ACK: begin
        rdata_d = rx_q;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      ABORT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      rx_q      <= '0;
      rdata_q   <= '0;
      mode_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      rx_q      <= rx_d;
      rdata_q   <= rdata_d;
      mode_q    <= mode_d;
    end
  end

  assign bus.req_ready    = (state_q == IDLE);
  assign bus.master_valid = tx_active;
  assign bus.wr_bus       = tx_active & shift_q[TOTAL-1];
  assign bus.mode         = mode_q;
  assign bus.master_ready = (state_q == ACK);
  assign bus.resp_valid   = (state_q == DONE) || (state_q == ABORT);
  assign bus.resp_err     = (state_q == ABORT);
  assign bus.resp_rdata   = rdata_q;
endmodule
`default_nettype wire

// File: tb/tb_master_port.sv
`default_nettype none
// ============================================================================
// tb_master_port -- scoreboard bench for master_port (honours MASTER_PORT_TIMEOUT_EN)
// Rev 1.0
// ============================================================================
module tb_master_port;
  localparam int AW = 16;
  localparam int DW = 8;
  localparam int TO = 64;
  localparam logic [14:0] RST_VEC = {1'b1, 14'd0};

  typedef struct packed {
    logic          err;
    logic [DW-1:0] rdata;
  } resp_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  master_port_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  master_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  resp_t         exp_q[$];
  logic          exp_bits[$];
  int            errors     = 0;
  int            checks     = 0;
  logic [DW-1:0] last_rdata = '0;

  function automatic logic [14:0] out_vec();
    return {bus.req_ready, bus.resp_valid, bus.resp_err, bus.resp_rdata, bus.mode,
            bus.wr_bus, bus.master_valid, bus.master_ready};
  endfunction

  // One complete transaction with a cycle-accurate slave model; the caller is
  // always positioned 1 time unit after a rising edge.
  task automatic do_txn(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        input logic [DW-1:0] rdata, input int drop_after, input int rst_after,
                        input logic stall, input logic hold_valid, input string name);
    int            sent = 0;
    int            rx_i = 0;
    int            mr   = 0;
    int            cyc;
    logic          seen_mv = 1'b0, got = 1'b0, mv_chk = 1'b0, rst_hit = 1'b0;
    logic          stall_ph = 1'b0, any = 1'b0, overrun = 1'b0;
    resp_t         r;
    logic [AW+DW-1:0] frame;
    frame = {addr, wdata};
    for (cyc = 0; cyc < 20 && !bus.req_ready; cyc++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++; $display("FAIL %s idle: req_ready=%b required 1", name, bus.req_ready);
    end
    bus.req_valid = 1'b1; bus.req_mode = wr; bus.req_addr = addr; bus.req_wdata = wdata;
    exp_bits.delete();
    for (int i = AW + DW - 1; i >= 0; i--) exp_bits.push_back(frame[i]);
    if (rst_after < 0) begin
      if (drop_after >= 0) exp_q.push_back(resp_t'({1'b1, last_rdata}));
      else if (wr)         exp_q.push_back(resp_t'({1'b0, last_rdata}));
      else begin
        exp_q.push_back(resp_t'({1'b0, rdata}));
        last_rdata = rdata;
      end
    end
    for (cyc = 0; cyc < 300; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 0) begin
        checks++;
        if (bus.req_ready !== 1'b0) begin
          errors++; $display("FAIL %s accept: req_ready=%b required 0", name, bus.req_ready);
        end
      end
      if (hold_valid) begin
        bus.req_addr = ~addr; bus.req_wdata = ~wdata; bus.req_mode = ~wr;
      end else begin
        bus.req_valid = 1'b0;
      end
      if (rst_hit) begin
        checks++;
        if (out_vec() !== RST_VEC) begin
          errors++; $display("FAIL %s reset_outputs: got %h required %h", name, out_vec(), RST_VEC);
        end
        rstn = 1'b1;
        break;
      end
      if (mv_chk) begin
        mv_chk = 1'b0; checks++;
        if (bus.master_valid !== 1'b0) begin
          errors++; $display("FAIL %s abort_mv: master_valid=%b required 0", name, bus.master_valid);
        end
      end
      if (bus.master_ready) mr++;
      if (bus.resp_valid) begin
        bus.req_valid = 1'b0;
        got = 1'b1;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL %s resp: unexpected resp_valid, none required", name);
        end else begin
          r = exp_q.pop_front();
          if ({bus.resp_err, bus.resp_rdata} !== r) begin
            errors++;
            $display("FAIL %s resp: err=%b rdata=%h required err=%b rdata=%h",
                     name, bus.resp_err, bus.resp_rdata, r.err, r.rdata);
          end
        end
        break;
      end
      bus.slave_ready = 1'b0;
      if (bus.master_valid) begin
        if (!seen_mv) begin
          seen_mv = 1'b1; checks++;
          if (bus.mode !== wr) begin
            errors++; $display("FAIL %s mode: mode=%b required %b", name, bus.mode, wr);
          end
        end else if (sent >= AW + DW) begin
          overrun = 1'b1;
          break;
        end else if (rst_after >= 0 && sent == rst_after) begin
          rstn = 1'b0; rst_hit = 1'b1;
        end else if (drop_after >= 0 && sent == drop_after) begin
          mv_chk = 1'b1;
        end else begin
          bus.slave_ready = 1'b1; checks++;
          if (bus.wr_bus !== exp_bits[sent]) begin
            errors++;
            $display("FAIL %s bit%0d: wr_bus=%b required %b", name, sent, bus.wr_bus, exp_bits[sent]);
          end
          sent++;
        end
      end
      bus.slave_valid = 1'b0;
      if (!wr && sent == AW + DW && !bus.master_valid && rx_i < DW) begin
        if (stall) stall_ph = ~stall_ph;
        if (!stall || stall_ph) begin
          bus.slave_valid = 1'b1;
          bus.rd_bus      = rdata[DW-1-rx_i];
          rx_i++;
        end
      end
    end
    bus.slave_ready = 1'b0; bus.slave_valid = 1'b0; bus.req_valid = 1'b0;
    if (overrun) begin
      checks++; errors++;
      $display("FAIL %s overrun: master_valid=1 after %0d bits, required 0", name, sent);
    end else if (rst_after >= 0) begin
      checks++;
      if (!rst_hit) begin
        errors++; $display("FAIL %s reset_point: reached bit %0d, required %0d", name, sent, rst_after);
      end
      rstn = 1'b1;
      last_rdata = '0;
      repeat (3) begin
        @(posedge clk); #1;
        if (bus.resp_valid) any = 1'b1;
      end
      checks++;
      if (any) begin
        errors++; $display("FAIL %s post_reset_resp: resp_valid seen=1 required 0", name);
      end
    end else begin
      checks++;
      if (!got) begin
        errors++; $display("FAIL %s timeout: no resp_valid within 300 cycles, required one", name);
      end else begin
        checks++;
        if (mr != ((wr || drop_after >= 0) ? 0 : 1)) begin
          errors++; $display("FAIL %s master_ready: pulses=%0d required %0d", name, mr,
                             (wr || drop_after >= 0) ? 0 : 1);
        end
        checks++;
        if (sent != ((drop_after >= 0) ? drop_after : AW + DW)) begin
          errors++; $display("FAIL %s bit_count: sent=%0d required %0d", name, sent,
                             (drop_after >= 0) ? drop_after : AW + DW);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
          errors++; $display("FAIL %s return_idle: req_ready=%b resp_valid=%b required 1/0",
                             name, bus.req_ready, bus.resp_valid);
        end
      end
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_vec() !== RST_VEC) begin
      errors++; $display("FAIL reset_values: got %h required %h", out_vec(), RST_VEC);
    end
    rstn = 1'b1;
  endtask

  task automatic test_write();
    do_txn(1'b1, 16'hA55A, 8'h3C, 8'h00, -1, -1, 1'b0, 1'b0, "write");
  endtask

  task automatic test_read();
    do_txn(1'b0, 16'h0010, 8'hFF, 8'hC3, -1, -1, 1'b0, 1'b0, "read");
  endtask

  task automatic test_read_stall();
    do_txn(1'b0, 16'h0020, 8'h00, 8'h81, -1, -1, 1'b1, 1'b0, "read_stall");
  endtask

  task automatic test_abort();
    do_txn(1'b1, 16'h1234, 8'h56, 8'h00, 5, -1, 1'b0, 1'b0, "abort");
  endtask

  task automatic test_back_to_back();
    do_txn(1'b1, 16'h0F0F, 8'hE1, 8'h00, -1, -1, 1'b0, 1'b1, "b2b_write");
    do_txn(1'b0, 16'hBEEF, 8'h00, 8'h5A, -1, -1, 1'b0, 1'b1, "b2b_read");
  endtask

  task automatic test_reset_mid();
    do_txn(1'b1, 16'h7E81, 8'h99, 8'h00, -1, 10, 1'b0, 1'b0, "reset_mid");
  endtask

  task automatic test_timeout();
    int   n;
    logic hit = 1'b0;
    resp_t r;
    bus.req_valid = 1'b1; bus.req_mode = 1'b0; bus.req_addr = 16'h4444; bus.req_wdata = 8'h00;
`ifdef MASTER_PORT_TIMEOUT_EN
    exp_q.push_back(resp_t'({1'b1, last_rdata}));
    for (n = 1; n <= TO + 10; n++) begin
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      if (bus.resp_valid) begin
        hit = 1'b1;
        break;
      end
    end
    checks++;
    if (!hit || n != TO + 1) begin
      errors++; $display("FAIL timeout_cycle: abort after %0d edges (hit=%b) required %0d", n, hit, TO + 1);
    end
    if (hit) begin
      r = exp_q.pop_front();
      checks++;
      if ({bus.resp_err, bus.resp_rdata} !== r) begin
        errors++; $display("FAIL timeout_resp: err=%b rdata=%h required err=%b rdata=%h",
                           bus.resp_err, bus.resp_rdata, r.err, r.rdata);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++; $display("FAIL timeout_idle: req_ready=%b required 1", bus.req_ready);
    end
`else
    for (n = 1; n <= 1000; n++) begin
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      if (n > 1 && (bus.resp_valid || !bus.master_valid)) hit = 1'b1;
    end
    checks++;
    if (hit || bus.master_valid !== 1'b1 || bus.req_ready !== 1'b0) begin
      errors++; $display("FAIL no_timeout: left REQ=%b master_valid=%b req_ready=%b required 0/1/0",
                         hit, bus.master_valid, bus.req_ready);
    end
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
`endif
  endtask

  initial begin
    bus.req_valid   = 1'b0; bus.req_mode  = 1'b0; bus.req_addr    = '0; bus.req_wdata = '0;
    bus.slave_ready = 1'b0; bus.rd_bus    = 1'b0; bus.slave_valid = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_read_stall();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    test_timeout();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: %0d responses outstanding, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end
endmodule
`default_nettype wire
